// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default bit timing, data width.
package uart_pkg;

    // Default clock cycles per UART bit (e.g. 100 MHz / 9600 baud).
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 10417;

    // Number of data bits carried by one frame.
    localparam int unsigned DATA_W = 8;

    // Frame-level state encoding, common to the receiver and transmitter.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        CLEANUP    = 3'd4,
        BREAK_WAIT = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_sync (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: shift the raw line through the two stages.
    always_comb begin
        meta_d = i_async;
        sync_d = meta_q;
    end

    // Synchroniser register pair; reset to line-idle.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, LSB first. The line is synchronised, the start
// bit is qualified at its midpoint, every data/stop bit is sampled mid-bit,
// and each good byte is announced with a one-cycle o_Rx_DV strobe. A low stop
// bit raises a one-cycle o_Rx_Frame_Err instead and the receiver then waits
// for the line to return high, so a held break does not re-trigger.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_Serial,
    output logic              o_Rx_DV,
    output logic [DATA_W-1:0] o_Rx_Byte,
    output logic              o_Rx_Active,
    output logic              o_Rx_Frame_Err
);

    // Counter terminal values: half a bit to reach the start-bit centre,
    // a full bit between successive sample points.
    localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

    // Synchronised serial line; the raw pin is never used directly.
    logic rx_s;

    uart_sync u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_async (i_Rx_Serial),
        .o_sync  (rx_s)
    );

    uart_state_e       state_q,  state_d;
    logic [15:0]       cnt_q,    cnt_d;
    logic [2:0]        idx_q,    idx_d;
    logic [DATA_W-1:0] shift_q,  shift_d;
    logic [DATA_W-1:0] byte_q,   byte_d;
    logic              dv_q,     dv_d;
    logic              ferr_q,   ferr_d;
    logic              active_q, active_d;

    // Frame FSM: next state, counters, byte assembly and output strobes.
    // Strobes default low so each lasts exactly the one cycle after it is set.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        ferr_d   = 1'b0;
        active_d = active_q;

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                idx_d = 3'd0;
                if (!rx_s) begin
                    state_d  = START;
                    active_d = 1'b1;
                end
            end

            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = 16'd0;
                    if (!rx_s) begin
                        state_d = DATA;
                    end else begin
                        // Line went back high before mid-bit: a glitch.
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d          = 16'd0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            STOP: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = CLEANUP;
                    end else begin
                        // Bad stop bit: keep the last good byte.
                        ferr_d  = 1'b1;
                        state_d = BREAK_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            CLEANUP: begin
                cnt_d    = 16'd0;
                active_d = 1'b0;
                state_d  = IDLE;
            end

            BREAK_WAIT: begin
                cnt_d = 16'd0;
                if (rx_s) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                // Unused encodings recover to IDLE.
                cnt_d    = 16'd0;
                idx_d    = 3'd0;
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // FSM and datapath registers; reset discards any partial frame.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            idx_q    <= 3'd0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            ferr_q   <= ferr_d;
            active_q <= active_d;
        end
    end

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Active    = active_q;
    assign o_Rx_Frame_Err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 8 clocks per bit. Frames are generated from a byte,
// a stop-bit choice and per-bit lengths; each frame's outcome (good byte or
// framing error) is queued and checked against the DUT's strobes in order.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       dv;
  logic [7:0] rbyte;
  logic       active;
  logic       ferr;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Rx_Serial    (rx),
    .o_Rx_DV        (dv),
    .o_Rx_Byte      (rbyte),
    .o_Rx_Active    (active),
    .o_Rx_Frame_Err (ferr)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int   cyc   = 0;
  logic rst_d = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  // ---------------- scoreboard state ----------------
  // Entry = {is_frame_error, byte}
  logic [8:0] exp_q[$];
  logic [7:0] model_byte = 8'h00;
  int n_cmp = 0;
  int n_err = 0;
  int dv_count = 0;
  int ferr_count = 0;
  int active_cnt = 0;
  int dv_cyc = 0;
  int last_t0 = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_d) begin
      check("reset dv", dv, 0);
      check("reset ferr", ferr, 0);
      check("reset active", active, 0);
      check("reset byte", rbyte, 0);
      model_byte = 8'h00;
    end else begin
      check("dv/ferr exclusive", dv & ferr, 0);
      if (dv) begin
        dv_count++;
        dv_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected dv", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("dv kind", e[8], 0);
          check("dv byte", rbyte, e[7:0]);
          model_byte = e[7:0];
        end
      end else if (ferr) begin
        ferr_count++;
        if (exp_q.size() == 0) begin
          check("unexpected ferr", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("ferr kind", e[8], 1);
        end
      end
      check("byte hold", rbyte, model_byte);
      if (active) active_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; holds the line at v for n clock edges.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame. Bit lengths (start + 8 data) jitter by +-1 with cumulative
  // drift kept within +-2 cycles so every mid-bit sample stays in its bit.
  task automatic drive_frame(input logic [7:0] b, input bit stop_ok,
                             input int hold_low, input bit jitter);
    int lens[9];
    int drift;
    int d;
    drift = 0;
    for (int k = 0; k < 9; k++) begin
      d = 0;
      if (jitter) begin
        d = int'($urandom_range(0, 2)) - 1;
        if (drift + d > 2 || drift + d < -2) d = -d;
        drift += d;
      end
      lens[k] = CPB + d;
    end
    exp_q.push_back({~stop_ok, b});
    last_t0 = cyc + 1;
    hold(1'b0, lens[0]);
    for (int k = 0; k < 8; k++) hold(b[k], lens[k+1]);
    if (stop_ok) begin
      hold(1'b1, CPB);
    end else begin
      hold(1'b0, hold_low);
      hold(1'b1, 1);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((active || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " idle timeout"}, (n < 3000), 1);
    hold(1'b1, 4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dv0;
    int fe0;
    logic [7:0] b;
    bit ok;
    bit jit;
    int gap;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(1'b1, 4);
    check("post-reset byte", rbyte, 8'h00);
    check("post-reset active", active, 0);

    // 1. single good frame, latency and active window
    active_cnt = 0;
    drive_frame(8'h37, 1'b1, 0, 1'b0);
    wait_idle("t1");
    check("t1 dv count", dv_count, 1);
    check("t1 latency", dv_cyc - last_t0, 78);
    check("t1 active cycles", active_cnt, 77);
    check("t1 byte", rbyte, 8'h37);

    // 2. back-to-back frames
    fe0 = ferr_count;
    drive_frame(8'h00, 1'b1, 0, 1'b0);
    drive_frame(8'hFF, 1'b1, 0, 1'b0);
    drive_frame(8'hA5, 1'b1, 0, 1'b0);
    wait_idle("t2");
    check("t2 dv count", dv_count, 4);
    check("t2 no ferr", ferr_count, fe0);
    check("t2 byte", rbyte, 8'hA5);

    // 3. start glitch
    dv0 = dv_count;
    fe0 = ferr_count;
    hold(1'b0, 2);
    hold(1'b1, 20);
    check("t3 active", active, 0);
    check("t3 no dv", dv_count, dv0);
    check("t3 no ferr", ferr_count, fe0);

    // 4. framing error with a 40-cycle break, then a good frame
    dv0 = dv_count;
    fe0 = ferr_count;
    drive_frame(8'h5A, 1'b0, 40, 1'b0);
    wait_idle("t4a");
    check("t4 ferr count", ferr_count, fe0 + 1);
    check("t4 no dv", dv_count, dv0);
    check("t4 byte kept", rbyte, 8'hA5);
    drive_frame(8'h3C, 1'b1, 0, 1'b0);
    wait_idle("t4b");
    check("t4 next byte", rbyte, 8'h3C);

    // 5. reset during data bit 4 of 0x81
    dv0 = dv_count;
    fe0 = ferr_count;
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, 3 * CPB);
    hold(1'b0, 3);
    rst = 1'b1;
    hold(1'b1, 1);
    rst = 1'b0;
    hold(1'b1, 20);
    check("t5 byte cleared", rbyte, 8'h00);
    check("t5 active", active, 0);
    check("t5 no dv", dv_count, dv0);
    check("t5 no ferr", ferr_count, fe0);
    drive_frame(8'h81, 1'b1, 0, 1'b0);
    wait_idle("t5b");
    check("t5 next byte", rbyte, 8'h81);

    // 6. baud jitter
    for (int i = 0; i < 3; i++) begin
      drive_frame(8'hC3, 1'b1, 0, 1'b1);
      hold(1'b1, 2);
    end
    wait_idle("t6");
    check("t6 byte", rbyte, 8'hC3);

    // random traffic
    for (int i = 0; i < 30; i++) begin
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 5) != 0);
      jit = ($urandom_range(0, 1) != 0);
      gap = int'($urandom_range(0, 3));
      if (jit || !ok) gap += 2;
      drive_frame(b, ok, CPB + int'($urandom_range(0, 30)), jit);
      hold(1'b1, gap);
    end
    wait_idle("random");
    check("queue drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: stimulus did not complete by cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
